// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control path:
// opcode constants, sequencer state encoding and PC source selects.
package cpu_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_REG = 2'b01;
    localparam logic [1:0] PC_SEL_IMM = 2'b10;

endpackage

// File: rtl/cpu_op_class.sv
// Combinational opcode classifier: groups the latched opcode into the
// categories the sequencer needs to pick its path through the phases.
module cpu_op_class
    import cpu_pkg::*;
(
    input  logic [3:0] op,
    output logic       is_alu,
    output logic       is_flag_op,
    output logic       is_mem,
    output logic       is_load,
    output logic       is_branch,
    output logic       is_reg_branch,
    output logic       is_halt
);

    // "ALU" here means any instruction that finishes with a plain register write-back.
    always_comb begin
        is_alu        = 1'b0;
        is_flag_op    = 1'b0;
        is_mem        = 1'b0;
        is_load       = 1'b0;
        is_branch     = 1'b0;
        is_reg_branch = 1'b0;
        is_halt       = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_XOR: begin
                is_alu     = 1'b1;
                is_flag_op = 1'b1;
            end
            OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
            OP_LLB, OP_LHB, OP_PCS: begin
                is_alu = 1'b1;
            end
            OP_LW: begin
                is_mem  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                is_mem = 1'b1;
            end
            OP_B: begin
                is_branch = 1'b1;
            end
            OP_BR: begin
                is_branch     = 1'b1;
                is_reg_branch = 1'b1;
            end
            OP_HLT: begin
                is_halt = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer stepping instructions through FETCH/DECODE/EXEC/MEM/WB/HALT.
// Optional performance counters are built only when CPU_SEQ_PERF_CNT_EN is defined.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       fetch_op,
    input  logic             mem_ready,
    input  logic             cond_true,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_wr,
    output logic             ir_we,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             rf_we,
    output logic             flag_we,
    output logic             retire,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op_q;
    logic       halt_seen_q;

    logic is_alu;
    logic is_flag_op;
    logic is_mem;
    logic is_load;
    logic is_branch;
    logic is_reg_branch;
    logic is_halt;

    cpu_op_class u_op_class (
        .op            (op_q),
        .is_alu        (is_alu),
        .is_flag_op    (is_flag_op),
        .is_mem        (is_mem),
        .is_load       (is_load),
        .is_branch     (is_branch),
        .is_reg_branch (is_reg_branch),
        .is_halt       (is_halt)
    );

    // Strobes are decoded straight from state/op/handshake so a zero-wait access
    // completes in its first cycle; everything is held quiet while reset is asserted.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_wr  = 1'b0;
        ir_we    = 1'b0;
        pc_we    = 1'b0;
        pc_sel   = PC_SEL_INC;
        rf_we    = 1'b0;
        flag_we  = 1'b0;
        retire   = 1'b0;
        halted   = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_sel  = PC_SEL_INC;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    state_d = is_halt ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    if (is_branch) begin
                        pc_we   = cond_true;
                        pc_sel  = is_reg_branch ? PC_SEL_REG : PC_SEL_IMM;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (is_mem) begin
                        state_d = ST_MEM;
                    end else if (is_alu) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_wr  = ~is_load;
                    if (mem_ready) begin
                        if (is_load) begin
                            state_d = ST_WB;
                        end else begin
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_WB: begin
                    rf_we   = 1'b1;
                    flag_we = is_flag_op;
                    retire  = 1'b1;
                    state_d = ST_FETCH;
                end
                ST_HALT: begin
                    halted = 1'b1;
                    retire = ~halt_seen_q;
                end
                default: begin
                    state_d = ST_FETCH;
                end
            endcase
        end
    end

    // halt_seen_q marks that the first HALT cycle has passed, so HALT retires exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FETCH;
            op_q        <= 4'b0000;
            halt_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            halt_seen_q <= (state_q == ST_HALT);
            if (state_q == ST_FETCH && mem_ready) begin
                op_q <= fetch_op;
            end
        end
    end

    assign state = state_q;

`ifdef CPU_SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            if (retire) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
            if (state_q != ST_HALT) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
            end
        end
    end

    assign retire_cnt = retire_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;
`else
    assign retire_cnt = '0;
    assign cycle_cnt  = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed and random instructions with random
// memory latencies, checked cycle by cycle against a phase-level script model.
`timescale 1ns/1ps
module tb_cpu_sequencer;

    localparam int CNT_W = 4;
    localparam logic [1:0] RDY_LOW  = 2'd0;
    localparam logic [1:0] RDY_HIGH = 2'd1;
    localparam logic [1:0] RDY_ANY  = 2'd2;

    typedef struct packed {
        logic [1:0]  rdy;
        logic        load_op;
        logic [13:0] exp;
    } step_t;

    logic             clk;
    logic             rst;
    logic [3:0]       fetch_op;
    logic             mem_ready;
    logic             cond_true;
    logic             imem_req;
    logic             dmem_req;
    logic             dmem_wr;
    logic             ir_we;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic             flag_we;
    logic             retire;
    logic             halted;
    logic [2:0]       state;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] cycle_cnt;

    int checks    = 0;
    int failures  = 0;
    int model_ret = 0;
    int model_cyc = 0;

    cpu_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch_op   (fetch_op),
        .mem_ready  (mem_ready),
        .cond_true  (cond_true),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .dmem_wr    (dmem_wr),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .rf_we      (rf_we),
        .flag_we    (flag_we),
        .retire     (retire),
        .halted     (halted),
        .state      (state),
        .retire_cnt (retire_cnt),
        .cycle_cnt  (cycle_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [13:0] pack(input logic imem, input logic dmem, input logic wr,
                                         input logic ir, input logic pcwe, input logic [1:0] sel,
                                         input logic rf, input logic fl, input logic ret,
                                         input logic hlt, input logic [2:0] st);
        return {imem, dmem, wr, ir, pcwe, sel, rf, fl, ret, hlt, st};
    endfunction

    function automatic logic [13:0] observed();
        return {imem_req, dmem_req, dmem_wr, ir_we, pc_we, pc_sel,
                rf_we, flag_we, retire, halted, state};
    endfunction

    function automatic logic [31:0] obsCounters();
        return {{(32 - 2*CNT_W){1'b0}}, retire_cnt, cycle_cnt};
    endfunction

    function automatic logic [31:0] expCounters();
`ifdef CPU_SEQ_PERF_CNT_EN
        return 32'(((model_ret % (1 << CNT_W)) << CNT_W) | (model_cyc % (1 << CNT_W)));
`else
        return 32'd0;
`endif
    endfunction

    function automatic step_t mkStep(input logic [1:0] rdy, input logic ld, input logic [13:0] exp);
        step_t s;
        s.rdy     = rdy;
        s.load_op = ld;
        s.exp     = exp;
        return s;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Builds the expected per-cycle script for one instruction from its phase rules,
    // then drives it; max_steps < 0 runs the whole instruction.
    task automatic applyStimulus(input logic [3:0] op, input logic cond, input int iwait,
                                 input int dwait, input int max_steps);
        step_t script[$];
        logic  is_b    = (op == 4'hC);
        logic  is_br   = (op == 4'hD);
        logic  is_lw   = (op == 4'h8);
        logic  is_sw   = (op == 4'h9);
        logic  is_flag = (op <= 4'h2);
        int    limit;

        for (int i = 0; i < iwait; i++)
            script.push_back(mkStep(RDY_LOW, 1'b0,
                pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)));
        script.push_back(mkStep(RDY_HIGH, 1'b1,
            pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)));
        script.push_back(mkStep(RDY_ANY, 1'b0,
            pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1)));

        if (op == 4'hF) begin
            script.push_back(mkStep(RDY_ANY, 1'b0,
                pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd5)));
            for (int i = 0; i < 20; i++)
                script.push_back(mkStep(RDY_ANY, 1'b0,
                    pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5)));
        end else begin
            if (is_b || is_br)
                script.push_back(mkStep(RDY_ANY, 1'b0,
                    pack(1'b0, 1'b0, 1'b0, 1'b0, cond, is_b ? 2'b10 : 2'b01,
                         1'b0, 1'b0, 1'b1, 1'b0, 3'd2)));
            else
                script.push_back(mkStep(RDY_ANY, 1'b0,
                    pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2)));
            if (is_lw || is_sw) begin
                for (int i = 0; i < dwait; i++)
                    script.push_back(mkStep(RDY_LOW, 1'b0,
                        pack(1'b0, 1'b1, is_sw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3)));
                script.push_back(mkStep(RDY_HIGH, 1'b0,
                    pack(1'b0, 1'b1, is_sw, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, is_sw, 1'b0, 3'd3)));
            end
            if (!is_b && !is_br && !is_sw)
                script.push_back(mkStep(RDY_ANY, 1'b0,
                    pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, is_flag, 1'b1, 1'b0, 3'd4)));
        end

        limit = (max_steps < 0) ? script.size() : max_steps;
        for (int i = 0; i < limit; i++) begin
            if (script[i].rdy == RDY_LOW)       mem_ready = 1'b0;
            else if (script[i].rdy == RDY_HIGH) mem_ready = 1'b1;
            else                                mem_ready = 1'($urandom_range(0, 1));
            fetch_op  = script[i].load_op ? op : 4'($urandom_range(0, 15));
            cond_true = cond;
            #2;
            checkOutput($sformatf("op%h_step%0d", op, i), {18'd0, observed()}, {18'd0, script[i].exp});
            checkOutput($sformatf("cnt_op%h_step%0d", op, i), obsCounters(), expCounters());
            if (script[i].exp[4]) model_ret++;
            if (script[i].exp[2:0] != 3'd5) model_cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        fetch_op  = 4'h0;
        cond_true = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset_out", {18'd0, observed()},
            {18'd0, pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0)});
        checkOutput("reset_cnt", obsCounters(), 32'd0);

        applyStimulus(4'h0, 1'b0, 0, 0, -1);
        applyStimulus(4'h8, 1'b0, 0, 2, -1);
        applyStimulus(4'hC, 1'b1, 1, 0, -1);
        applyStimulus(4'hC, 1'b0, 0, 0, -1);
        applyStimulus(4'hD, 1'b1, 2, 0, -1);
        applyStimulus(4'h9, 1'b0, 0, 1, -1);
        applyStimulus(4'hE, 1'b1, 0, 0, -1);

        // Abandon a store mid-wait, then complete the next fetch on a stale ready.
        applyStimulus(4'h9, 1'b0, 0, 3, 4);
        mem_ready = 1'b0;
        #1;
        checkOutput("pre_rst_dmem", {31'd0, dmem_req}, 32'd1);
        rst       = 1'b1;
        mem_ready = 1'b1;
        #1;
        checkOutput("rst_mid_mem", {18'd0, observed()}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        model_ret = 0;
        model_cyc = 0;
        #1;
        checkOutput("rst_release", {28'd0, state, imem_req}, {28'd0, 3'd0, 1'b1});
        applyStimulus(4'h1, 1'b0, 0, 0, -1);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(4'($urandom_range(0, 14)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), -1);
        end

        applyStimulus(4'hF, 1'b0, 1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
